// File: rtl/trigger_config_tx.sv
// trigger_config_tx: serialises a mask/pattern pair onto the trigger's 32-bit
// setting bus as 1, mask, 0, 2, pattern, 0 and owns the trigger start line.
module trigger_config_tx #(
  parameter int HOLD   = 2,
  parameter int SETTLE = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_cfg_mask,
  input  logic [31:0] i_cfg_pattern,
  input  logic        i_cfg_valid,
  output logic        o_cfg_ready,
  input  logic        i_arm,
  input  logic        i_disarm,
  output logic [31:0] o_setting,
  output logic        o_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int MAXC = (HOLD > SETTLE) ? HOLD : SETTLE;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_RELOAD   = CW'(HOLD - 1);
  localparam logic [CW-1:0] SETTLE_RELOAD = CW'(SETTLE - 1);
  localparam bit            SETTLE_ONE    = (SETTLE == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_M, S_VAL_M, S_END_M, S_CMD_P, S_VAL_P, S_END_P, S_SETTLE
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [31:0]    r_setting;
  logic [31:0]    r_mask;
  logic [31:0]    r_pattern;
  logic           r_ready;
  logic           r_busy;
  logic           r_done;
  logic           r_err;
  logic           r_start;
  logic           r_arm_pending;

  logic w_fire;
  logic w_bad;
  logic w_accept;
  logic w_last;
  logic w_finish;
  logic w_done_next;

  // The receiver only latches on word changes and uses 0 as terminator, so a
  // mask equal to the mask command (1) or a pattern equal to the pattern
  // command (2), or either being 0, would be misread.
  assign w_fire   = i_cfg_valid && r_ready;
  assign w_bad    = (i_cfg_mask == 32'd0) || (i_cfg_mask == 32'd1) ||
                    (i_cfg_pattern == 32'd0) || (i_cfg_pattern == 32'd2);
  assign w_accept = w_fire && !w_bad;
  assign w_last   = (r_cnt == '0);
  assign w_finish = (r_state == S_SETTLE) && w_last;
  // done must coincide with the final SETTLE cycle, so it is raised on entry to it
  assign w_done_next = (SETTLE_ONE && (r_state == S_END_P) && w_last) ||
                       (!SETTLE_ONE && (r_state == S_SETTLE) && (r_cnt == CW'(1)));

  // Sequencer: walks the six command words, each held HOLD cycles, then settles
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_setting <= '0;
      r_mask    <= '0;
      r_pattern <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= w_done_next;
      r_err  <= w_fire && w_bad;
      if (r_state == S_IDLE) begin
        r_ready <= 1'b1;
        if (w_accept) begin
          r_mask    <= i_cfg_mask;
          r_pattern <= i_cfg_pattern;
          r_state   <= S_CMD_M;
          r_setting <= 32'd1;
          r_cnt     <= HOLD_RELOAD;
          r_busy    <= 1'b1;
          r_ready   <= 1'b0;
        end
      end else if (!w_last) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_cnt <= HOLD_RELOAD;
        case (r_state)
          S_CMD_M: begin r_state <= S_VAL_M; r_setting <= r_mask;    end
          S_VAL_M: begin r_state <= S_END_M; r_setting <= 32'd0;     end
          S_END_M: begin r_state <= S_CMD_P; r_setting <= 32'd2;     end
          S_CMD_P: begin r_state <= S_VAL_P; r_setting <= r_pattern; end
          S_VAL_P: begin r_state <= S_END_P; r_setting <= 32'd0;     end
          S_END_P: begin
            r_state   <= S_SETTLE;
            r_setting <= 32'd0;
            r_cnt     <= SETTLE_RELOAD;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  // Start line: disarm dominates, reprogramming drops it, arms during a
  // sequence are deferred until the sequence finishes
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_start       <= 1'b0;
      r_arm_pending <= 1'b0;
    end else if (i_disarm) begin
      r_start       <= 1'b0;
      r_arm_pending <= 1'b0;
    end else if (w_accept) begin
      r_start       <= 1'b0;
      r_arm_pending <= i_arm;
    end else if (w_finish && (r_arm_pending || i_arm)) begin
      r_start       <= 1'b1;
      r_arm_pending <= 1'b0;
    end else if (i_arm) begin
      if (r_state == S_IDLE) r_start <= 1'b1;
      else                   r_arm_pending <= 1'b1;
    end
  end

  assign o_cfg_ready = r_ready;
  assign o_setting   = r_setting;
  assign o_start     = r_start;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule
